// File: rtl/multi_wave_gen.sv
// multi_wave_gen: periodic waveform source (triangle, saw-up, saw-down, square).
//
// A prescaler sets the tick rate. Each tick steps the phase by step_i, and the
// phase is clamped to the amplitude. The configuration is held in shadow
// registers. These follow the inputs while idle. While running they reload
// only on the tick that starts a new period, so a period never changes shape
// part-way through.
//
// Ports:
//   clk_i           clock, all logic on posedge
//   rst_i           synchronous reset, active-high (priority over ena_i)
//   ena_i           run enable; low holds the idle/reset state
//   mode_i          0 triangle, 1 saw-up, 2 saw-down, 3 square
//   amplitude_i     peak value (inclusive)
//   step_i          phase increment per tick; 0 behaves as 1
//   prescaler_i     tick every prescaler_i+1 clocks
//   duty_i          square: output high while phase < duty_i
//   data_o          current sample (registered)
//   sample_valid_o  1-cycle pulse on each tick
//   cycle_start_o   1-cycle pulse on the tick that starts a new period
module multi_wave_gen #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ena_i,
    input  logic [1:0]         mode_i,
    input  logic [DATA_W-1:0]  amplitude_i,
    input  logic [DATA_W-1:0]  step_i,
    input  logic [PRESC_W-1:0] prescaler_i,
    input  logic [DATA_W-1:0]  duty_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               sample_valid_o,
    output logic               cycle_start_o
);

    typedef enum logic [1:0] {ModeTri, ModeSawUp, ModeSawDn, ModeSquare} mode_e;

    localparam logic [DATA_W-1:0]  DataOne = DATA_W'(1);
    localparam logic [PRESC_W-1:0] CntOne  = PRESC_W'(1);

    mode_e               mode_sh_q, mode_sh_d;
    logic [DATA_W-1:0]   amp_sh_q, amp_sh_d;
    logic [DATA_W-1:0]   step_sh_q, step_sh_d;
    logic [DATA_W-1:0]   duty_sh_q, duty_sh_d;
    logic [PRESC_W-1:0]  presc_sh_q, presc_sh_d;
    logic [PRESC_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   ph_q, ph_d;      // saw/square phase, or triangle value
    logic                dir_q, dir_d;    // triangle direction, 0 = up
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                cs_q, cs_d;

    logic                tick;
    logic [DATA_W-1:0]   step_eff;
    logic [DATA_W:0]     sum_w;
    logic [DATA_W-1:0]   up_clamp;
    logic [DATA_W-1:0]   dn_clamp;
    logic                wrap;
    logic [DATA_W-1:0]   ph_saw;

    always_comb begin
        tick     = ena_i && (cnt_q == presc_sh_q);
        step_eff = (step_sh_q == '0) ? DataOne : step_sh_q;
        // One extra bit so that ph + step cannot wrap before the clamp.
        sum_w    = {1'b0, ph_q} + {1'b0, step_eff};
        up_clamp = (sum_w > {1'b0, amp_sh_q}) ? amp_sh_q : sum_w[DATA_W-1:0];
        dn_clamp = (step_eff >= ph_q) ? '0 : ph_q - step_eff;
        wrap     = (ph_q == amp_sh_q);
        ph_saw   = wrap ? '0 : up_clamp;
    end

    always_comb begin
        mode_sh_d  = mode_sh_q;
        amp_sh_d   = amp_sh_q;
        step_sh_d  = step_sh_q;
        duty_sh_d  = duty_sh_q;
        presc_sh_d = presc_sh_q;
        cnt_d      = cnt_q;
        ph_d       = ph_q;
        dir_d      = dir_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        cs_d       = 1'b0;

        if (rst_i || !ena_i) begin
            cnt_d  = '0;
            ph_d   = '0;
            dir_d  = 1'b0;
            data_d = '0;
        end else if (!tick) begin
            cnt_d = cnt_q + CntOne;
        end else begin
            cnt_d   = '0;
            valid_d = 1'b1;
            unique case (mode_sh_q)
                ModeTri: begin
                    if (amp_sh_q == '0) begin
                        ph_d   = '0;
                        dir_d  = 1'b0;
                        data_d = '0;
                        cs_d   = 1'b1;
                    end else if (!dir_q) begin
                        ph_d   = up_clamp;
                        data_d = up_clamp;
                        // Turn at the peak now so the peak is not repeated.
                        if (up_clamp == amp_sh_q) dir_d = 1'b1;
                    end else begin
                        ph_d   = dn_clamp;
                        data_d = dn_clamp;
                        if (dn_clamp == '0) begin
                            dir_d = 1'b0;
                            cs_d  = 1'b1;
                        end
                    end
                end
                ModeSawUp: begin
                    ph_d   = ph_saw;
                    dir_d  = 1'b0;
                    data_d = ph_saw;
                    cs_d   = wrap;
                end
                ModeSawDn: begin
                    ph_d   = ph_saw;
                    dir_d  = 1'b0;
                    data_d = amp_sh_q - ph_saw;
                    cs_d   = wrap;
                end
                ModeSquare: begin
                    ph_d   = ph_saw;
                    dir_d  = 1'b0;
                    data_d = (ph_saw < duty_sh_q) ? amp_sh_q : '0;
                    cs_d   = wrap;
                end
                default: ;
            endcase
        end

        // Shadows are transparent while idle. While running they reload only
        // at a period boundary.
        if (rst_i || !ena_i || cs_d) begin
            mode_sh_d  = mode_e'(mode_i);
            amp_sh_d   = amplitude_i;
            step_sh_d  = step_i;
            duty_sh_d  = duty_i;
            presc_sh_d = prescaler_i;
        end
    end

    always_ff @(posedge clk_i) begin
        mode_sh_q  <= mode_sh_d;
        amp_sh_q   <= amp_sh_d;
        step_sh_q  <= step_sh_d;
        duty_sh_q  <= duty_sh_d;
        presc_sh_q <= presc_sh_d;
        cnt_q      <= cnt_d;
        ph_q       <= ph_d;
        dir_q      <= dir_d;
        data_q     <= data_d;
        valid_q    <= valid_d;
        cs_q       <= cs_d;
    end

    assign data_o         = data_q;
    assign sample_valid_o = valid_q;
    assign cycle_start_o  = cs_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
module tb_multi_wave_gen;

    typedef struct {
        logic [15:0] data;
        logic        cs;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        ena_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [15:0] amplitude_i = '0;
    logic [15:0] step_i = '0;
    logic [15:0] prescaler_i = '0;
    logic [15:0] duty_i = '0;
    logic [15:0] data_o;
    logic        sample_valid_o;
    logic        cycle_start_o;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   since = 0;
    int   gap_cur = 1;

    multi_wave_gen #(.DATA_W(16), .PRESC_W(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .ena_i         (ena_i),
        .mode_i        (mode_i),
        .amplitude_i   (amplitude_i),
        .step_i        (step_i),
        .prescaler_i   (prescaler_i),
        .duty_i        (duty_i),
        .data_o        (data_o),
        .sample_valid_o(sample_valid_o),
        .cycle_start_o (cycle_start_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expected sample for each sample_valid pulse.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_i || !ena_i) begin
            since = 0;
            check("idle_no_pulse", {30'd0, sample_valid_o, cycle_start_o}, 0);
        end else begin
            since++;
            if (sample_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", int'(data_o), int'(e.data));
                    check("cycle_start", int'(cycle_start_o), int'(e.cs));
                    check("tick_gap", since, e.gap);
                end
                since = 0;
            end else begin
                check("cs_without_valid", int'(cycle_start_o), 0);
            end
        end
    end

    task automatic p(input int d, input logic cs);
        exp_t e;
        e.data = 16'(d);
        e.cs   = cs;
        e.gap  = gap_cur;
        exp_q.push_back(e);
    endtask

    task automatic configure(input int m, input int a, input int s, input int pr,
                             input int du);
        @(negedge clk);
        ena_i       = 1'b0;
        mode_i      = 2'(m);
        amplitude_i = 16'(a);
        step_i      = 16'(s);
        prescaler_i = 16'(pr);
        duty_i      = 16'(du);
        gap_cur     = pr + 1;
        repeat (2) @(negedge clk);
    endtask

    // Waits (bounded) until at most 'left' expected samples remain.
    task automatic wait_left(input int left, input string name);
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (exp_q.size() <= left) break;
        end
        check(name, exp_q.size() <= left ? 1 : 0, 1);
        if (exp_q.size() > left) exp_q.delete();
    endtask

    task automatic drain(input string name);
        ena_i = 1'b1;
        wait_left(0, name);
        ena_i = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", int'(data_o), 0);
        check("rst_valid", int'(sample_valid_o), 0);
        check("rst_cs", int'(cycle_start_o), 0);
        @(negedge clk);
        rst_i = 1'b0;

        // 1: triangle amp=4 step=1 presc=0
        configure(0, 4, 1, 0, 0);
        p(1,0); p(2,0); p(3,0); p(4,0); p(3,0); p(2,0); p(1,0); p(0,1); p(1,0);
        drain("t1_drain");

        // 2: triangle amp=5 step=2 presc=2
        configure(0, 5, 2, 2, 0);
        p(2,0); p(4,0); p(5,0); p(3,0); p(1,0); p(0,1); p(2,0);
        drain("t2_drain");

        // 3: saw-up and saw-down amp=3 step=1
        configure(1, 3, 1, 0, 0);
        p(1,0); p(2,0); p(3,0); p(0,1); p(1,0);
        drain("t3_sawup_drain");
        configure(2, 3, 1, 0, 0);
        p(2,0); p(1,0); p(0,0); p(3,1); p(2,0);
        drain("t3_sawdn_drain");

        // Saw-up clamp at amplitude, step 0 treated as 1, full-scale no-wrap, amp 0
        configure(1, 5, 3, 0, 0);
        p(3,0); p(5,0); p(0,1); p(3,0);
        drain("clamp_drain");
        configure(1, 2, 0, 0, 0);
        p(1,0); p(2,0); p(0,1); p(1,0);
        drain("step0_drain");
        configure(1, 16'hFFFF, 16'hFFFF, 0, 0);
        p(16'hFFFF,0); p(0,1); p(16'hFFFF,0);
        drain("fullscale_drain");
        configure(0, 0, 1, 0, 0);
        p(0,1); p(0,1); p(0,1);
        drain("amp0_drain");

        // 4: square amp=3 duty=2, then duty=0 and duty>amp
        configure(3, 3, 1, 0, 2);
        p(3,0); p(0,0); p(0,0); p(3,1); p(3,0); p(0,0);
        drain("t4_sq_drain");
        configure(3, 3, 1, 0, 0);
        p(0,0); p(0,0); p(0,0); p(0,1); p(0,0);
        drain("t4_duty0_drain");
        configure(3, 3, 1, 1, 9);
        p(3,0); p(3,0); p(3,0); p(3,1);
        drain("t4_dutybig_drain");

        // 5: amplitude 4 -> 8 changed right after start of a triangle period
        configure(0, 4, 1, 0, 0);
        p(1,0); p(2,0); p(3,0); p(4,0); p(3,0); p(2,0); p(1,0); p(0,1);
        for (int v = 1; v <= 8; v++) p(v, 0);
        for (int v = 7; v >= 1; v--) p(v, 0);
        p(0,1); p(1,0);
        ena_i = 1'b1;
        @(negedge clk);
        amplitude_i = 16'd8;
        wait_left(0, "t5_drain");
        ena_i = 1'b0;

        // 6: rst mid-ramp with ena high, then ena drop mid-ramp
        configure(0, 5, 2, 0, 0);
        p(2,0); p(4,0); p(5,0);
        ena_i = 1'b1;
        wait_left(1, "t6_pre_rst");
        rst_i = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("t6_rst_data", int'(data_o), 0);
        check("t6_rst_valid", int'(sample_valid_o), 0);
        @(negedge clk);
        rst_i = 1'b0;
        p(2,0); p(4,0); p(5,0);
        wait_left(1, "t6_pre_ena_drop");
        ena_i = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("t6_idle_data", int'(data_o), 0);
        check("t6_idle_cs", int'(cycle_start_o), 0);
        @(negedge clk);
        p(2,0); p(4,0); p(5,0); p(3,0);
        drain("t6_restart_drain");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
